// File: rtl/fc1_bias_relu_stream.sv
// Captures the FC1 result vector, adds a per-neuron bias from BRAM, clamps to [0, max positive]
// and streams one element per valid/ready handshake to the FC2 input stage.
module fc1_bias_relu_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_MAP = 120,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fc_done,
  input  logic [OUTPUT_MAP*DATA_WIDTH-1:0] in,
  output logic                             in_ready,
  output logic [ADDR_WIDTH-1:0]            bias_read_addr,
  output logic                             bias_read_en,
  input  logic [DATA_WIDTH-1:0]            bias_data,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUTPUT_MAP - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(0);

  state_t                          state_r;
  state_t                          state_next_s;
  logic [ADDR_WIDTH-1:0]           idx_r;
  logic [OUTPUT_MAP*DATA_WIDTH-1:0] vec_r;
  logic [DATA_WIDTH-1:0]           elem_s;
  logic                            accept_s;
  logic                            is_last_s;

  // Sum in one extra bit so the sign of the true sum is never lost before clamping.
  function automatic logic [DATA_WIDTH-1:0] bias_relu(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0]   sum_v;
    logic [DATA_WIDTH-1:0] res_v;
    sum_v = {x[DATA_WIDTH-1], x} + {b[DATA_WIDTH-1], b};
    if (sum_v[DATA_WIDTH]) begin
      res_v = {DATA_WIDTH{1'b0}};
    end else if (sum_v[DATA_WIDTH-1]) begin
      res_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      res_v = sum_v[DATA_WIDTH-1:0];
    end
    return res_v;
  endfunction

  assign elem_s    = vec_r[idx_r*DATA_WIDTH +: DATA_WIDTH];
  assign accept_s  = (state_r == ST_EMIT) && out_valid && out_ready;
  assign is_last_s = (idx_r == LAST_IDX);
  assign in_ready  = (state_r == ST_IDLE) && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fc_done) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: state_next_s = ST_WAIT;
      ST_WAIT:  state_next_s = ST_EMIT;
      ST_EMIT: begin
        if (accept_s && is_last_s) begin
          state_next_s = ST_DONE;
        end else if (accept_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: vector capture, bias fetch, output register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r          <= IDX_ZERO;
      bias_read_en   <= 1'b0;
      bias_read_addr <= IDX_ZERO;
      out_data       <= {DATA_WIDTH{1'b0}};
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      done           <= 1'b0;
    end else begin
      bias_read_en <= 1'b0;
      done         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fc_done) begin
            vec_r          <= in;
            idx_r          <= IDX_ZERO;
            bias_read_en   <= 1'b1;
            bias_read_addr <= IDX_ZERO;
          end
        end
        ST_WAIT: begin
          out_data  <= bias_relu(elem_s, bias_data);
          out_valid <= 1'b1;
          out_last  <= is_last_s;
        end
        ST_EMIT: begin
          if (accept_s) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (is_last_s) begin
              done <= 1'b1;
            end else begin
              idx_r          <= idx_r + IDX_ONE;
              bias_read_en   <= 1'b1;
              bias_read_addr <= idx_r + IDX_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc1_bias_relu_stream.sv
// Randomized scoreboard bench for fc1_bias_relu_stream with a bias BRAM model and
// an arithmetic reference computed from integer clamp rules.
module tb_fc1_bias_relu_stream;
  localparam int DW = 16;
  localparam int N  = 120;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fc_done = 1'b1;
  logic [N*DW-1:0] in_vec = '0;
  logic          in_ready;
  logic [AW-1:0] bias_read_addr;
  logic          bias_read_en;
  logic [DW-1:0] bias_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          done;

  fc1_bias_relu_stream #(.DATA_WIDTH(DW), .OUTPUT_MAP(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .fc_done(fc_done), .in(in_vec), .in_ready(in_ready),
    .bias_read_addr(bias_read_addr), .bias_read_en(bias_read_en), .bias_data(bias_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] bias_mem [0:127];
  always @(posedge clk) if (bias_read_en) bias_data <= bias_mem[bias_read_addr];

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            exp_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0, errors = 0;
  int beats = 0, dones = 0, done_cyc = 0, addr_exp = 0;
  int c0 = 0, b0 = 0, d0 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_relu(input int x, input int b);
    int s;
    s = x + b;
    if (s < 0) return 0;
    if (s > 32767) return 32767;
    return s;
  endfunction

  // Monitor: checks bias addresses and pops the scoreboard on each accepted beat.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bias_read_en) begin
        check("bias_addr", bias_read_addr, addr_exp);
        addr_exp++;
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_last", out_last, mon_e.last);
          if (mon_e.exp_cyc >= 0) check("beat_cycle", cyc, mon_e.exp_cyc);
        end
        beats++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_stream(input bit plan);
    int px[5] = '{100, -50, 30000, -32768, 0};
    int pb[5] = '{-20, 10, 5000, -32768, 0};
    for (int i = 0; i < 128; i++) bias_mem[i] = DW'($urandom);
    for (int k = 0; k < N; k++) in_vec[k*DW +: DW] = DW'($urandom);
    if (plan) begin
      for (int k = 0; k < 5; k++) begin
        in_vec[k*DW +: DW] = DW'(px[k]);
        bias_mem[k] = DW'(pb[k]);
      end
    end
  endtask

  task automatic start_stream(input bit timed);
    exp_t e;
    c0 = cyc + 1;
    for (int k = 0; k < N; k++) begin
      e.data = DW'(ref_relu(int'($signed(in_vec[k*DW +: DW])), int'(bias_mem[k])));
      e.last = (k == N - 1);
      e.exp_cyc = timed ? (c0 + 2 + 3 * k) : -1;
      sb.push_back(e);
    end
    addr_exp = 0;
    b0 = beats;
    d0 = dones;
    fc_done = 1'b1;
    tick();
    fc_done = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd, input bit iso);
    bit iso_done = 1'b0;
    for (int t = 0; t < 5000 && dones == d0; t++) begin
      out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (iso && !iso_done && (beats - b0) >= 20) begin
        in_vec = ~in_vec;
        fc_done = 1'b1;
        iso_done = 1'b1;
      end else begin
        fc_done = 1'b0;
      end
      tick();
    end
    fc_done = 1'b0;
    out_ready = 1'b1;
    check("done_seen", dones, d0 + 1);
    check("beat_count", beats - b0, N);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int acc, bounded;
    logic [DW-1:0] d7;
    logic [AW-1:0] a7;

    // Reset held with fc_done asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {out_data, out_valid, out_last, done, bias_read_en, bias_read_addr}, 0);
      check("reset_in_ready", in_ready, 0);
    end
    rst = 1'b0;
    fc_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_in_ready", in_ready, 1);
      check("idle_no_read", bias_read_en, 0);
    end

    // Full timed vector including arithmetic corner cases
    load_stream(1'b1);
    start_stream(1'b1);
    run_to_done(1'b0, 1'b0);
    check("done_cycle", done_cyc, c0 + 360);
    check("in_ready_after_done", in_ready, 1);
    check("ready_cycle", cyc, c0 + 361);

    // Backpressure on element 7, then random backpressure with input isolation
    load_stream(1'b0);
    start_stream(1'b0);
    bounded = 0;
    for (int t = 0; t < 200 && !(out_valid && (beats - b0) == 7); t++) tick();
    check("elem7_reached", out_valid && (beats - b0) == 7, 1);
    out_ready = 1'b0;
    d7 = out_data;
    a7 = bias_read_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, d7);
      check("bp_no_read", bias_read_en, 0);
      check("bp_addr", bias_read_addr, a7);
    end
    out_ready = 1'b1;
    acc = cyc;
    tick();
    for (int t = 0; t < 20 && !(out_valid && (beats - b0) == 8); t++) tick();
    check("elem8_cycle", cyc, acc + 3);
    run_to_done(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_queued_start", bias_read_en, 0);
    end
    check("single_done", dones, d0 + 1);

    // Reset after element 50 is accepted, then a fresh timed stream
    load_stream(1'b0);
    start_stream(1'b0);
    for (int t = 0; t < 400 && (beats - b0) < 51; t++) tick();
    check("elem50_accepted", beats - b0, 51);
    rst = 1'b1;
    sb.delete();
    tick();
    check("abort_outputs", {out_data, out_valid, out_last, done, bias_read_en, bias_read_addr}, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_done", dones, d0);
    load_stream(1'b0);
    start_stream(1'b1);
    run_to_done(1'b0, 1'b0);
    check("restart_done_cycle", done_cyc, c0 + 360);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
